// File: rtl/mtsp_phase_issue_if.sv
// rtl/mtsp_phase_issue_if.sv - bundle-in / beat-out handshake bundle for the phase issue stage
//
// Groups everything between the coordinate stage, the issue stage and the ALU:
//   flush                          drop the held bundle
//   in_valid / in_ready            bundle handshake
//   in_uinstx4                     {p0_m, p0_s, p1_m, p1_s}, MSB first
//   in_addr_dest / in_addr_rel     reference addresses travelling with the bundle
//   out_valid / out_ready          issue beat handshake
//   out_uinstx2 / out_phase        {main, slave} of the issued phase and its phase number
//   out_addr_dest / out_addr_rel   held reference addresses
//   out_beat_cnt                   saturating count of completed beats
// master = upstream/ALU side, slave = the issue stage.

interface mtsp_phase_issue_if #(
    parameter int UINST_W = 32,
    parameter int GPR_W   = 6,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 16
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [4*UINST_W-1:0]   in_uinstx4;
    logic [GPR_W-1:0]       in_addr_dest;
    logic [IDX_W-1:0]       in_addr_rel;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*UINST_W-1:0]   out_uinstx2;
    logic                   out_phase;
    logic [GPR_W-1:0]       out_addr_dest;
    logic [IDX_W-1:0]       out_addr_rel;
    logic [CNT_W-1:0]       out_beat_cnt;

    modport master (
        output flush, in_valid, in_uinstx4, in_addr_dest, in_addr_rel, out_ready,
        input  in_ready, out_valid, out_uinstx2, out_phase, out_addr_dest, out_addr_rel,
               out_beat_cnt
    );

    modport slave (
        input  flush, in_valid, in_uinstx4, in_addr_dest, in_addr_rel, out_ready,
        output in_ready, out_valid, out_uinstx2, out_phase, out_addr_dest, out_addr_rel,
               out_beat_cnt
    );
endinterface

// File: rtl/mtsp_phase_issue.sv
// rtl/mtsp_phase_issue.sv - issues a held UINSTx4 bundle to the ALU as up to two main/slave phases
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   mtsp_phase_issue_if.slave (bundle input, beat output, flush, beat counter)
// A phase whose main and slave both have nEN (bit UINST_W-1) set is skipped.
// All outputs are registered except in_ready, which looks at out_ready so that a
// new bundle can be taken in the same cycle as the last beat of the current one.

module mtsp_phase_issue #(
    parameter int UINST_W = 32,
    parameter int GPR_W   = 6,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    mtsp_phase_issue_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, P0, P1} state_t;

    state_t                 state, state_n, load_state;
    logic [4*UINST_W-1:0]   bundle_q, bundle_src;
    logic                   hs, last, accept, in_ready;
    logic                   en0_in, en1_in, en1_held;
    logic                   out_valid_q, out_phase_q;
    logic [2*UINST_W-1:0]   out_uinstx2_q;
    logic [GPR_W-1:0]       out_addr_dest_q;
    logic [IDX_W-1:0]       out_addr_rel_q;
    logic [CNT_W-1:0]       cnt_q;

    assign hs       = out_valid_q & bus.out_ready;
    assign en0_in   = ~(bus.in_uinstx4[4*UINST_W-1] & bus.in_uinstx4[3*UINST_W-1]);
    assign en1_in   = ~(bus.in_uinstx4[2*UINST_W-1] & bus.in_uinstx4[UINST_W-1]);
    assign en1_held = ~(bundle_q[2*UINST_W-1] & bundle_q[UINST_W-1]);

    // The current beat is the bundle's final one: phase 1, or phase 0 with phase 1 skipped.
    assign last     = (state == P1) | ((state == P0) & ~en1_held);
    assign in_ready = ~rst & ~bus.flush & ((state == IDLE) | (hs & last));
    assign accept   = bus.in_valid & in_ready;

    // A bundle with both phases disabled is absorbed without producing a beat.
    assign load_state = en0_in ? P0 : (en1_in ? P1 : IDLE);

    // Output data is taken from the incoming bundle on the accept cycle so the first
    // beat is presented the cycle after accept.
    assign bundle_src = accept ? bus.in_uinstx4 : bundle_q;

    always_comb begin
        state_n = state;
        if (bus.flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_n = load_state;
                P0: begin
                    if (hs) begin
                        if (en1_held)    state_n = P1;
                        else if (accept) state_n = load_state;
                        else             state_n = IDLE;
                    end
                end
                P1: begin
                    if (hs) state_n = accept ? load_state : IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bundle_q        <= '0;
            out_valid_q     <= 1'b0;
            out_phase_q     <= 1'b0;
            out_uinstx2_q   <= '0;
            out_addr_dest_q <= '0;
            out_addr_rel_q  <= '0;
            cnt_q           <= '0;
        end else begin
            state         <= state_n;
            out_valid_q   <= (state_n != IDLE);
            out_phase_q   <= (state_n == P1);
            out_uinstx2_q <= (state_n == P1) ? bundle_src[2*UINST_W-1:0]
                                             : bundle_src[4*UINST_W-1:2*UINST_W];
            if (accept) begin
                bundle_q        <= bus.in_uinstx4;
                out_addr_dest_q <= bus.in_addr_dest;
                out_addr_rel_q  <= bus.in_addr_rel;
            end
            // A beat coincident with flush is dropped and not counted.
            if (hs && !bus.flush && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_phase     = out_phase_q;
    assign bus.out_uinstx2   = out_uinstx2_q;
    assign bus.out_addr_dest = out_addr_dest_q;
    assign bus.out_addr_rel  = out_addr_rel_q;
    assign bus.out_beat_cnt  = cnt_q;
endmodule

// File: tb/tb_mtsp_phase_issue.sv
// tb/tb_mtsp_phase_issue.sv - self-checking bench for mtsp_phase_issue

module tb_mtsp_phase_issue;
    localparam int UW = 32;
    localparam int GW = 6;
    localparam int IW = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic            phase;
        logic [2*UW-1:0] u;
        logic [GW-1:0]   d;
        logic [IW-1:0]   r;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mtsp_phase_issue_if #(.UINST_W(UW), .GPR_W(GW), .IDX_W(IW), .CNT_W(CW)) bus();

    mtsp_phase_issue #(.UINST_W(UW), .GPR_W(GW), .IDX_W(IW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          exp_q[$];
    exp_t          mon_e, mon_got;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] model_cnt = '0;

    // Scoreboard monitor: counter tracked against a saturating model, beats popped in order.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_checks++;
            if (bus.out_beat_cnt !== model_cnt) begin
                n_fail++;
                $display("FAIL beat_cnt_track: got %0d expected %0d at %0t", bus.out_beat_cnt, model_cnt, $time);
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && bus.flush !== 1'b1) begin
                n_checks++;
                mon_got = '{bus.out_phase, bus.out_uinstx2, bus.out_addr_dest, bus.out_addr_rel};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none at %0t", mon_got, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_got !== mon_e) begin
                        n_fail++;
                        $display("FAIL beat: got %h expected %h at %0t", mon_got, mon_e, $time);
                    end
                end
                if (model_cnt != {CW{1'b1}}) model_cnt = model_cnt + 1'b1;
            end
        end
    end

    function automatic logic [4*UW-1:0] make_bundle(input logic [3:0] nen);
        logic [4*UW-1:0] b;
        for (int k = 0; k < 4; k++) b[k*UW +: UW] = $urandom;
        b[4*UW-1] = nen[3];
        b[3*UW-1] = nen[2];
        b[2*UW-1] = nen[1];
        b[UW-1]   = nen[0];
        return b;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4*UW-1:0] b, input logic [GW-1:0] d, input logic [IW-1:0] r);
        if (!(b[4*UW-1] & b[3*UW-1])) exp_q.push_back('{1'b0, b[4*UW-1:2*UW], d, r});
        if (!(b[2*UW-1] & b[UW-1]))   exp_q.push_back('{1'b1, b[2*UW-1:0], d, r});
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push_bundle(input logic [4*UW-1:0] b, input logic [GW-1:0] d, input logic [IW-1:0] r);
        logic ok;
        ok = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_uinstx4   = b;
        bus.in_addr_dest = d;
        bus.in_addr_rel  = r;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end else begin
            push_exp(b, d, r);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: pending beats got %0d expected 0", exp_q.size());
        end
        cyc();
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.flush        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.in_uinstx4   = '0;
        bus.in_addr_dest = '0;
        bus.in_addr_rel  = '0;
        repeat (2) cyc();
        exp_q.delete();
        model_cnt = '0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b1;
        bus.in_valid     = 1'b1;
        bus.in_uinstx4   = make_bundle(4'b0000);
        bus.in_addr_dest = 6'h3f;
        bus.in_addr_rel  = 4'hf;
        repeat (2) cyc();
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.out_uinstx2 !== '0 || bus.out_phase !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_data: got %h/%b expected 0/0", bus.out_uinstx2, bus.out_phase);
        end
        n_checks++;
        if (bus.out_addr_dest !== '0 || bus.out_addr_rel !== '0 || bus.out_beat_cnt !== '0) begin
            n_fail++; $display("FAIL reset_addr_cnt: got %h/%h/%h expected 0/0/0", bus.out_addr_dest, bus.out_addr_rel, bus.out_beat_cnt);
        end
        bus.in_valid = 1'b0;
        exp_q.delete();
        model_cnt = '0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", bus.in_ready); end
        cyc();
    endtask

    task automatic test_two_phase();
        logic [4*UW-1:0] b;
        do_reset();
        bus.out_ready = 1'b1;
        b = make_bundle(4'b0000);
        push_bundle(b, 6'h2a, 4'h5);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_phase !== 1'b0 || bus.out_uinstx2 !== b[4*UW-1:2*UW] || bus.out_addr_dest !== 6'h2a) begin
            n_fail++; $display("FAIL two_phase_t1: got v=%b ph=%b u=%h d=%h expected v=1 ph=0 u=%h d=2a",
                               bus.out_valid, bus.out_phase, bus.out_uinstx2, bus.out_addr_dest, b[4*UW-1:2*UW]);
        end
        cyc();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_phase !== 1'b1 || bus.out_uinstx2 !== b[2*UW-1:0] || bus.out_addr_dest !== 6'h2a) begin
            n_fail++; $display("FAIL two_phase_t2: got v=%b ph=%b u=%h d=%h expected v=1 ph=1 u=%h d=2a",
                               bus.out_valid, bus.out_phase, bus.out_uinstx2, bus.out_addr_dest, b[2*UW-1:0]);
        end
        cyc();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_beat_cnt !== 4'd2) begin
            n_fail++; $display("FAIL two_phase_end: got v=%b cnt=%0d expected v=0 cnt=2", bus.out_valid, bus.out_beat_cnt);
        end
    endtask

    task automatic test_single_phase();
        logic [3:0] nen_list [5];
        logic [3:0] nen;
        int         exp_cnt;
        logic       exp_ph;
        nen_list = '{4'b0011, 4'b0111, 4'b1100, 4'b1101, 4'b1111};
        do_reset();
        bus.out_ready = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            nen = nen_list[i];
            exp_ph = (nen[3] & nen[2]);
            push_bundle(make_bundle(nen), 6'(i + 7), 4'(i));
            if (nen == 4'b1111) begin
                n_checks++;
                if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL skip_all_valid: got %b expected 0", bus.out_valid); end
                @(negedge clk);
                n_checks++;
                if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL skip_all_ready: got %b expected 1", bus.in_ready); end
            end else begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_phase !== exp_ph) begin
                    n_fail++; $display("FAIL single_beat_%0d: got v=%b ph=%b expected v=1 ph=%b", i, bus.out_valid, bus.out_phase, exp_ph);
                end
                @(negedge clk);
                n_checks++;
                if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_last_ready_%0d: got %b expected 1", i, bus.in_ready); end
                exp_cnt++;
            end
            cyc();
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.out_beat_cnt !== CW'(exp_cnt)) begin
                n_fail++; $display("FAIL single_after_%0d: got v=%b cnt=%0d expected v=0 cnt=%0d", i, bus.out_valid, bus.out_beat_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4*UW-1:0] a, b;
        logic [3:0]      rdy;
        logic            ph;
        do_reset();
        bus.out_ready = 1'b1;
        a = make_bundle(4'b0000);
        b = make_bundle(4'b0000);
        rdy = 4'b0101;
        bus.in_valid     = 1'b1;
        bus.in_uinstx4   = a;
        bus.in_addr_dest = 6'h11;
        bus.in_addr_rel  = 4'h1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 4) begin
                n_checks++;
                if (bus.in_ready !== rdy[c]) begin n_fail++; $display("FAIL b2b_ready_c%0d: got %b expected %b", c, bus.in_ready, rdy[c]); end
            end
            if (c > 0) begin
                ph = (c % 2 == 0);
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_phase !== ph) begin
                    n_fail++; $display("FAIL b2b_beat_c%0d: got v=%b ph=%b expected v=1 ph=%b", c, bus.out_valid, bus.out_phase, ph);
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) push_exp(bus.in_uinstx4, bus.in_addr_dest, bus.in_addr_rel);
            cyc();
            if (c == 0) begin
                bus.in_uinstx4   = b;
                bus.in_addr_dest = 6'h22;
                bus.in_addr_rel  = 4'h2;
            end
            if (c == 2) bus.in_valid = 1'b0;
        end
        wait_drain();
        n_checks++;
        if (bus.out_beat_cnt !== 4'd4) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 4", bus.out_beat_cnt); end
    endtask

    task automatic test_backpressure();
        logic [4*UW-1:0] b;
        do_reset();
        bus.out_ready = 1'b0;
        b = make_bundle(4'b0000);
        push_bundle(b, 6'h15, 4'ha);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_phase !== 1'b0 || bus.out_uinstx2 !== b[4*UW-1:2*UW] ||
                bus.out_addr_dest !== 6'h15 || bus.out_addr_rel !== 4'ha) begin
                n_fail++; $display("FAIL stall_hold_s%0d: got v=%b ph=%b u=%h expected v=1 ph=0 u=%h",
                                   s, bus.out_valid, bus.out_phase, bus.out_uinstx2, b[4*UW-1:2*UW]);
            end
            n_checks++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_s%0d: got %b expected 0", s, bus.in_ready); end
            cyc();
        end
        bus.out_ready = 1'b1;
        cyc();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_phase !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: got v=%b ph=%b expected v=1 ph=1", bus.out_valid, bus.out_phase);
        end
        wait_drain();
        n_checks++;
        if (bus.out_beat_cnt !== 4'd2) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 2", bus.out_beat_cnt); end
    endtask

    task automatic test_flush();
        logic [4*UW-1:0] b;
        do_reset();
        bus.out_ready    = 1'b1;
        b                = make_bundle(4'b0000);
        bus.in_valid     = 1'b1;
        bus.in_uinstx4   = b;
        bus.in_addr_dest = 6'h09;
        bus.in_addr_rel  = 4'h3;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_accept: got %b expected 1", bus.in_ready); end
        exp_q.push_back('{1'b0, b[4*UW-1:2*UW], 6'h09, 4'h3});
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_phase !== 1'b1) begin
            n_fail++; $display("FAIL flush_p1: got v=%b ph=%b expected v=1 ph=1", bus.out_valid, bus.out_phase);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", bus.in_ready); end
        cyc();
        bus.flush = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_beat_cnt !== 4'd1) begin
            n_fail++; $display("FAIL flush_after: got v=%b cnt=%0d expected v=0 cnt=1", bus.out_valid, bus.out_beat_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b expected 1", bus.in_ready); end
        cyc();
    endtask

    task automatic test_saturate();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) push_bundle(make_bundle(4'b0011), 6'(i), 4'(i));
        wait_drain();
        n_checks++;
        if (bus.out_beat_cnt !== 4'hf) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 15", bus.out_beat_cnt); end
        push_bundle(make_bundle(4'b0000), 6'h30, 4'h7);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        model_cnt = '0;
        cyc();
        rst = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_beat_cnt !== '0) begin
            n_fail++; $display("FAIL mid_reset: got v=%b cnt=%0d expected v=0 cnt=0", bus.out_valid, bus.out_beat_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", bus.in_ready); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_two_phase();
        test_single_phase();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
